// File: rtl/rob_commit_pkg.sv
// Shared types and sizing for the ROB commit stage.
package rob_pkg;

  localparam int unsigned EXT_COUNT = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned TOTAL_W   = 32;

  // Width of an encoded "count minus one" across the head window.
  function automatic int unsigned count_width(input int unsigned ext);
    return (ext > 1) ? $clog2(ext) : 1;
  endfunction

  localparam int unsigned CNT_W = count_width(EXT_COUNT);
  // Holds 0..EXT_COUNT inclusive.
  localparam int unsigned N_W   = CNT_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  dest_reg;
    logic              dest_en;
    logic              is_store;
    logic              exception;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } commit_state_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle between the ROB head window, the commit stage and its consumers.
interface rob_commit_if;
  import rob_pkg::*;

  logic [EXT_COUNT-1:0]             slot_valid;
  rob_entry_t [EXT_COUNT-1:0]       slot_data;
  logic                             rob_empty;
  logic                             consume;
  logic [CNT_W-1:0]                 consume_count;
  logic [EXT_COUNT-1:0]             rf_we;
  logic [EXT_COUNT-1:0][REG_W-1:0]  rf_waddr;
  logic [EXT_COUNT-1:0][DATA_W-1:0] rf_wdata;
  logic                             st_valid;
  logic                             st_ready;
  logic [ADDR_W-1:0]                st_addr;
  logic [DATA_W-1:0]                st_data;
  logic                             flush;
  logic [PC_W-1:0]                  exc_pc;
  logic [TOTAL_W-1:0]               commit_total;

  // ROB / environment side.
  modport master (
    output slot_valid, slot_data, rob_empty, st_ready,
    input  consume, consume_count, rf_we, rf_waddr, rf_wdata,
    input  st_valid, st_addr, st_data, flush, exc_pc, commit_total
  );

  // Commit stage side.
  modport slave (
    input  slot_valid, slot_data, rob_empty, st_ready,
    output consume, consume_count, rf_we, rf_waddr, rf_wdata,
    output st_valid, st_addr, st_data, flush, exc_pc, commit_total
  );

endinterface

// File: rtl/rob_commit_select.sv
// Combinational prefix selection over the ROB head window.
module rob_commit_select
  import rob_pkg::*;
(
  input  logic [EXT_COUNT-1:0]       slot_valid,
  input  rob_entry_t [EXT_COUNT-1:0] slot_data,
  input  logic                       st_ready,
  output logic [N_W-1:0]             n_c,
  output logic [CNT_W-1:0]           st_idx_c,
  output logic                       st_valid_c,
  output logic [EXT_COUNT-1:0]       we_mask_c
);

  logic stop;

  // Longest in-order prefix: ends at an incomplete/excepting slot, a second
  // store, or a store the buffer cannot take this cycle.
  always_comb begin
    n_c        = '0;
    st_idx_c   = '0;
    st_valid_c = 1'b0;
    stop       = 1'b0;
    for (int unsigned i = 0; i < EXT_COUNT; i++) begin
      if (!stop) begin
        if (!slot_valid[i] || slot_data[i].exception) begin
          stop = 1'b1;
        end else if (slot_data[i].is_store) begin
          if (st_valid_c) begin
            stop = 1'b1;
          end else begin
            st_valid_c = 1'b1;
            st_idx_c   = CNT_W'(i);
            if (st_ready) n_c = N_W'(i + 1);
            else          stop = 1'b1;
          end
        end else begin
          n_c = N_W'(i + 1);
        end
      end
    end
  end

  // Per-lane write enable: inside the prefix, real destination, and not
  // overwritten by a younger lane of the same group.
  always_comb begin
    we_mask_c = '0;
    for (int unsigned i = 0; i < EXT_COUNT; i++) begin
      we_mask_c[i] = (N_W'(i) < n_c) && slot_data[i].dest_en &&
                     (slot_data[i].dest_reg != '0);
      for (int unsigned j = i + 1; j < EXT_COUNT; j++) begin
        if ((N_W'(j) < n_c) && slot_data[j].dest_en &&
            (slot_data[j].dest_reg == slot_data[i].dest_reg)) begin
          we_mask_c[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order commit stage on the ROB head: retire, write back, flush on exception.
module rob_commit
  import rob_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  rob_commit_if.slave  bus
);

  commit_state_t              state;
  commit_state_t              state_next;
  logic [N_W-1:0]             n_c;
  logic [CNT_W-1:0]           st_idx_c;
  logic                       sel_st_valid_c;
  logic [EXT_COUNT-1:0]       we_mask_c;
  logic                       head_exc_c;
  logic                       consume_c;
  logic                       st_valid_c;

  logic [EXT_COUNT-1:0]             rf_we_q;
  logic [EXT_COUNT-1:0][REG_W-1:0]  rf_waddr_q;
  logic [EXT_COUNT-1:0][DATA_W-1:0] rf_wdata_q;
  logic                             flush_q;
  logic [PC_W-1:0]                  exc_pc_q;
  logic [TOTAL_W-1:0]               commit_total_q;

  rob_commit_select u_select (
    .slot_valid (bus.slot_valid),
    .slot_data  (bus.slot_data),
    .st_ready   (bus.st_ready),
    .n_c        (n_c),
    .st_idx_c   (st_idx_c),
    .st_valid_c (sel_st_valid_c),
    .we_mask_c  (we_mask_c)
  );

  assign head_exc_c = bus.slot_valid[0] && bus.slot_data[0].exception;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state plus the combinational ROB/store handshake.
  always_comb begin
    state_next = state;
    consume_c  = 1'b0;
    st_valid_c = 1'b0;
    case (state)
      RUN: begin
        consume_c  = !reset && (n_c != '0);
        st_valid_c = !reset && sel_st_valid_c;
        if (head_exc_c) state_next = FLUSH;
      end
      FLUSH:   state_next = DRAIN;
      DRAIN:   if (bus.rob_empty) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Register-file pipeline, flush pulse, exception PC and commit counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q        <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      flush_q        <= 1'b0;
      exc_pc_q       <= '0;
      commit_total_q <= '0;
    end else begin
      rf_we_q <= consume_c ? we_mask_c : '0;
      if (consume_c) begin
        for (int unsigned i = 0; i < EXT_COUNT; i++) begin
          rf_waddr_q[i] <= bus.slot_data[i].dest_reg;
          rf_wdata_q[i] <= bus.slot_data[i].result;
        end
        commit_total_q <= commit_total_q + TOTAL_W'(n_c);
      end
      flush_q <= (state_next == FLUSH);
      if ((state == RUN) && head_exc_c) exc_pc_q <= bus.slot_data[0].pc;
    end
  end

  assign bus.consume       = consume_c;
  assign bus.consume_count = consume_c ? CNT_W'(n_c - N_W'(1)) : '0;
  assign bus.st_valid      = st_valid_c;
  assign bus.st_addr       = bus.slot_data[st_idx_c].addr;
  assign bus.st_data       = bus.slot_data[st_idx_c].result;
  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.flush         = flush_q;
  assign bus.exc_pc        = exc_pc_q;
  assign bus.commit_total  = commit_total_q;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: vector table plus exception/reset sequences.
module tb_rob_commit;
  import rob_pkg::*;

  typedef struct {
    string                      name;
    logic [EXT_COUNT-1:0]       valid;
    rob_entry_t [EXT_COUNT-1:0] ent;
    logic                       st_ready;
    logic                       rob_empty;
    logic                       rst;
    logic                       exp_consume;
    logic [CNT_W-1:0]           exp_cnt;
    logic                       exp_stv;
    int                         exp_st_idx;
    logic [EXT_COUNT-1:0]       exp_we;
    logic                       exp_flush;
  } vec_t;

  typedef struct packed {
    logic [EXT_COUNT-1:0]             we;
    logic [EXT_COUNT-1:0][REG_W-1:0]  waddr;
    logic [EXT_COUNT-1:0][DATA_W-1:0] wdata;
  } rf_exp_t;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] total_model = '0;
  logic [31:0] exc_model   = '0;
  rf_exp_t rf_q[$];
  vec_t    tbl[$];

  rob_commit_if bus();

  rob_commit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic rob_entry_t mk(input logic [31:0] pc, input logic [31:0] res,
                                    input int dst, input bit den, input bit st, input bit ex);
    rob_entry_t e;
    e.pc        = pc;
    e.result    = res;
    e.addr      = 32'h1000 + pc;
    e.dest_reg  = REG_W'(dst);
    e.dest_en   = den;
    e.is_store  = st;
    e.exception = ex;
    return e;
  endfunction

  function automatic vec_t blank(input string nm);
    vec_t v;
    v.name        = nm;
    v.valid       = '0;
    v.ent         = '0;
    v.st_ready    = 1'b1;
    v.rob_empty   = 1'b0;
    v.rst         = 1'b0;
    v.exp_consume = 1'b0;
    v.exp_cnt     = '0;
    v.exp_stv     = 1'b0;
    v.exp_st_idx  = 0;
    v.exp_we      = '0;
    v.exp_flush   = 1'b0;
    return v;
  endfunction

  function automatic vec_t alu1(input string nm, input logic [31:0] pc,
                                input bit empty, input bit exp_c);
    vec_t v;
    v             = blank(nm);
    v.valid       = 4'b0001;
    v.ent[0]      = mk(pc, pc + 1, 20, 1, 0, 0);
    v.rob_empty   = empty;
    v.exp_consume = exp_c;
    v.exp_we      = exp_c ? 4'b0001 : 4'b0000;
    return v;
  endfunction

  function automatic vec_t exc1(input string nm, input logic [31:0] pc);
    vec_t v;
    v           = blank(nm);
    v.valid     = 4'b0001;
    v.ent[0]    = mk(pc, 0, 0, 0, 0, 1);
    v.exp_flush = 1'b1;
    return v;
  endfunction

  // Drive one cycle, check handshake mid-cycle, check registered outputs after the edge.
  task automatic apply(input vec_t v);
    rf_exp_t e;
    bus.slot_valid = v.valid;
    bus.slot_data  = v.ent;
    bus.st_ready   = v.st_ready;
    bus.rob_empty  = v.rob_empty;
    reset          = v.rst;
    #1;
    chk({v.name, " consume"}, 64'(bus.consume), 64'(v.exp_consume));
    if (v.exp_consume) chk({v.name, " consume_count"}, 64'(bus.consume_count), 64'(v.exp_cnt));
    chk({v.name, " st_valid"}, 64'(bus.st_valid), 64'(v.exp_stv));
    if (v.exp_stv) begin
      chk({v.name, " st_addr"}, 64'(bus.st_addr), 64'(v.ent[v.exp_st_idx].addr));
      chk({v.name, " st_data"}, 64'(bus.st_data), 64'(v.ent[v.exp_st_idx].result));
    end
    e.we = v.exp_we;
    for (int i = 0; i < EXT_COUNT; i++) begin
      e.waddr[i] = v.ent[i].dest_reg;
      e.wdata[i] = v.ent[i].result;
    end
    rf_q.push_back(e);
    if (v.rst) begin
      total_model = '0;
      exc_model   = '0;
    end else if (v.exp_consume) begin
      total_model = total_model + 32'(v.exp_cnt) + 32'd1;
    end
    @(posedge clock);
    #1;
    e = rf_q.pop_front();
    chk({v.name, " rf_we"}, 64'(bus.rf_we), 64'(e.we));
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (e.we[i]) begin
        chk({v.name, " rf_waddr"}, 64'(bus.rf_waddr[i]), 64'(e.waddr[i]));
        chk({v.name, " rf_wdata"}, 64'(bus.rf_wdata[i]), 64'(e.wdata[i]));
      end
    end
    chk({v.name, " flush"}, 64'(bus.flush), 64'(v.exp_flush));
    chk({v.name, " exc_pc"}, 64'(bus.exc_pc), 64'(exc_model));
    chk({v.name, " commit_total"}, 64'(bus.commit_total), 64'(total_model));
  endtask

  initial begin
    vec_t v;

    // Reset with a busy window presented: nothing may be consumed or offered.
    v       = blank("reset");
    v.rst   = 1'b1;
    v.valid = 4'b1111;
    for (int i = 0; i < EXT_COUNT; i++) v.ent[i] = mk(32'(i), 32'(i), i + 1, 1, i[0], 0);
    apply(v);
    apply(v);

    // ---- Single-cycle vector table ----
    v = blank("alu4"); v.valid = 4'b1111;
    for (int i = 0; i < EXT_COUNT; i++) v.ent[i] = mk(32'(i), 32'(i), i + 1, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 3; v.exp_we = 4'b1111; tbl.push_back(v);

    v = blank("st_pair"); v.valid = 4'b1111;
    v.ent[0] = mk(16, 32'h11, 6, 1, 0, 0); v.ent[1] = mk(20, 32'h22, 0, 0, 1, 0);
    v.ent[2] = mk(24, 32'h33, 0, 0, 1, 0); v.ent[3] = mk(28, 32'h44, 8, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 1; v.exp_stv = 1; v.exp_st_idx = 1; v.exp_we = 4'b0001;
    tbl.push_back(v);

    v = blank("st_second"); v.valid = 4'b1011;
    v.ent[0] = mk(24, 32'h33, 0, 0, 1, 0); v.ent[1] = mk(28, 32'h44, 7, 1, 0, 0);
    v.ent[2] = mk(32, 32'h55, 9, 1, 0, 0); v.ent[3] = mk(36, 32'h66, 10, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 1; v.exp_stv = 1; v.exp_st_idx = 0; v.exp_we = 4'b0010;
    tbl.push_back(v);

    v = blank("head_invalid"); v.valid = 4'b1110;
    for (int i = 0; i < EXT_COUNT; i++) v.ent[i] = mk(32'(40 + 4 * i), 32'(i), i + 1, 1, 0, 0);
    tbl.push_back(v);

    v = blank("dup_r5"); v.valid = 4'b0111;
    v.ent[0] = mk(48, 32'hA, 5, 1, 0, 0); v.ent[1] = mk(52, 32'hB, 5, 1, 0, 0);
    v.ent[2] = mk(56, 32'hC, 0, 1, 0, 0); v.ent[3] = mk(60, 32'hD, 3, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 2; v.exp_we = 4'b0010; tbl.push_back(v);

    v = blank("st_wait"); v.valid = 4'b0011; v.st_ready = 0;
    v.ent[0] = mk(64, 32'h77, 0, 0, 1, 0); v.ent[1] = mk(68, 1, 2, 1, 0, 0);
    v.exp_stv = 1; v.exp_st_idx = 0; tbl.push_back(v);

    v = blank("st_mid_wait"); v.valid = 4'b1111; v.st_ready = 0;
    v.ent[0] = mk(72, 1, 11, 1, 0, 0); v.ent[1] = mk(76, 2, 12, 1, 0, 0);
    v.ent[2] = mk(80, 3, 0, 0, 1, 0);  v.ent[3] = mk(84, 4, 13, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 1; v.exp_stv = 1; v.exp_st_idx = 2; v.exp_we = 4'b0011;
    tbl.push_back(v);

    v = blank("one_nodest"); v.valid = 4'b0001;
    v.ent[0] = mk(88, 5, 14, 0, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 0; tbl.push_back(v);

    v = blank("exc_slot1"); v.valid = 4'b0111;
    v.ent[0] = mk(92, 6, 15, 1, 0, 0); v.ent[1] = mk(96, 7, 16, 1, 0, 1);
    v.ent[2] = mk(100, 8, 17, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 0; v.exp_we = 4'b0001; tbl.push_back(v);

    v = blank("st_then_exc"); v.valid = 4'b0011; v.st_ready = 0;
    v.ent[0] = mk(104, 9, 0, 0, 1, 0); v.ent[1] = mk(108, 0, 0, 0, 0, 1);
    v.exp_stv = 1; v.exp_st_idx = 0; tbl.push_back(v);

    v = blank("store_after_exc"); v.valid = 4'b0111;
    v.ent[0] = mk(112, 1, 18, 1, 0, 0); v.ent[1] = mk(116, 0, 0, 0, 0, 1);
    v.ent[2] = mk(120, 2, 0, 0, 1, 0);
    v.exp_consume = 1; v.exp_cnt = 0; v.exp_we = 4'b0001; tbl.push_back(v);

    v = blank("full_store_last"); v.valid = 4'b1111;
    v.ent[0] = mk(124, 1, 19, 1, 0, 0); v.ent[1] = mk(128, 2, 20, 1, 0, 0);
    v.ent[2] = mk(132, 3, 21, 1, 0, 0); v.ent[3] = mk(136, 32'hBEEF, 0, 0, 1, 0);
    v.exp_consume = 1; v.exp_cnt = 3; v.exp_stv = 1; v.exp_st_idx = 3; v.exp_we = 4'b0111;
    tbl.push_back(v);

    v = blank("dup_beyond_n"); v.valid = 4'b0111;
    v.ent[0] = mk(140, 1, 9, 1, 0, 0); v.ent[1] = mk(144, 0, 0, 0, 0, 1);
    v.ent[2] = mk(148, 2, 9, 1, 0, 0);
    v.exp_consume = 1; v.exp_cnt = 0; v.exp_we = 4'b0001; tbl.push_back(v);

    foreach (tbl[k]) apply(tbl[k]);

    // ---- Store stalled at head for three cycles, then accepted ----
    for (int k = 0; k < 3; k++) begin
      v = blank("st_stall"); v.valid = 4'b0001; v.st_ready = 0;
      v.ent[0] = mk(32'h60, 32'h99, 0, 0, 1, 0);
      v.exp_stv = 1; v.exp_st_idx = 0;
      apply(v);
    end
    v = blank("st_go"); v.valid = 4'b0001;
    v.ent[0] = mk(32'h60, 32'h99, 0, 0, 1, 0);
    v.exp_consume = 1; v.exp_cnt = 0; v.exp_stv = 1; v.exp_st_idx = 0;
    apply(v);

    // ---- Exception: drain older work, flush, wait for empty ROB ----
    v = blank("pre_exc"); v.valid = 4'b0111;
    v.ent[0] = mk(32'h38, 1, 1, 1, 0, 0); v.ent[1] = mk(32'h3c, 2, 2, 1, 0, 0);
    v.ent[2] = mk(32'h40, 3, 3, 1, 0, 1);
    v.exp_consume = 1; v.exp_cnt = 1; v.exp_we = 4'b0011;
    apply(v);
    exc_model = 32'h40;
    apply(exc1("exc_head", 32'h40));
    v = blank("flush_cycle"); v.valid = 4'b0001;
    v.ent[0] = mk(32'h44, 5, 0, 0, 1, 0);
    apply(v);
    apply(alu1("drain_wait0", 32'h48, 0, 0));
    apply(alu1("drain_wait1", 32'h48, 0, 0));
    apply(alu1("drain_empty", 32'h48, 1, 0));
    apply(alu1("run_again", 32'h48, 0, 1));

    // ---- ROB already empty on DRAIN entry: one DRAIN cycle only ----
    exc_model = 32'h50;
    apply(exc1("exc2", 32'h50));
    apply(alu1("flush_empty", 32'h54, 1, 0));
    apply(alu1("drain_one", 32'h54, 1, 0));
    apply(alu1("run_after_one", 32'h54, 1, 1));

    // ---- Reset in the middle of DRAIN ----
    exc_model = 32'h80;
    apply(exc1("exc3", 32'h80));
    apply(alu1("flush3", 32'h84, 0, 0));
    apply(alu1("drain3", 32'h84, 0, 0));
    v = alu1("reset_drain", 32'h84, 0, 0);
    v.rst = 1'b1;
    apply(v);
    apply(alu1("run_after_rst", 32'h88, 0, 1));

    // ---- Reset while in FLUSH ----
    exc_model = 32'h90;
    apply(exc1("exc4", 32'h90));
    v = alu1("reset_flush", 32'h94, 0, 0);
    v.rst = 1'b1;
    apply(v);
    apply(alu1("run_after_rst2", 32'h98, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
